// File: rtl/fetch_queue.sv
// Prefetch queue for the instruction fetch unit.
// Fetches words from a variable-latency imem over req/ack and buffers
// {instruction, pc4} pairs for decode. A redirect flushes the queue and
// turns any outstanding request into a discard.
module fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_addr,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic                         imem_ack,
  input  logic [DATA_W-1:0]            imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            instruction,
  output logic [ADDR_W-1:0]            pc4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc4;
  } entry_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] old_addr;   // address of the request being discarded
  logic [PW-1:0]     wr_ptr, rd_ptr;
  entry_t            mem [DEPTH];

  logic              pop, push;
  logic [CW:0]       cnt_after;  // occupancy after this cycle's push/pop

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = (state == WAIT) & imem_ack & ~redirect;
  assign cnt_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

  assign instruction = out_valid ? mem[rd_ptr].instr : '0;
  assign pc4         = out_valid ? mem[rd_ptr].pc4   : '0;

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; redirect dominates every other condition
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!redirect && ((count < CW'(DEPTH)) || pop)) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect)      state_nxt = imem_ack ? IDLE : DISCARD;
        else if (imem_ack) state_nxt = (cnt_after < (CW+1)'(DEPTH)) ? WAIT : IDLE;
      end
      DISCARD: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: request is held through WAIT and DISCARD
  always_comb begin
    imem_req  = (state == WAIT) || (state == DISCARD);
    imem_addr = (state == DISCARD) ? old_addr : fetch_pc;
  end

  // Fetch PC, pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      old_addr <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_addr[ADDR_W-1:2], 2'b00};
      if (state == WAIT) old_addr <= fetch_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; contents are masked by out_valid so no reset is needed
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{instr: imem_rdata, pc4: imem_addr + ADDR_W'(4)};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small latency-programmable imem model.
module tb_fetch_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        out_ready = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] instruction;
  logic [31:0] pc4;
  logic [2:0]  count;

  int   lat      = 0;     // 0: ack in the request cycle, N: ack on the Nth cycle
  logic dead     = 1'b0;  // return 0xDEAD instead of the address
  int   wait_cnt = 0;
  int   ack_cnt  = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   a0;

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .pc4(pc4), .count(count)
  );

  always #5 clock = ~clock;

  assign imem_ack   = imem_req && (lat == 0 || wait_cnt == lat - 1);
  assign imem_rdata = dead ? 32'hDEAD : imem_addr;

  always @(posedge clock or negedge reset) begin
    if (!reset)                    wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  always @(negedge clock) begin
    if (reset && imem_req && imem_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset state, then zero-latency streaming
    @(posedge clock); #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc4", pc4, 0);
    reset = 1'b1;
    step();
    chk("t1_req", imem_req, 1);
    chk("t1_addr0", imem_addr, 0);
    chk("t1_valid0", out_valid, 0);
    step();
    chk("t1_pc4_a", pc4, 32'h4);
    chk("t1_ins_a", instruction, 32'h0);
    chk("t1_addr1", imem_addr, 32'h4);
    step();
    chk("t1_pc4_b", pc4, 32'h8);
    chk("t1_ins_b", instruction, 32'h4);
    chk("t1_cnt_b", count, 1);
    step();
    chk("t1_pc4_c", pc4, 32'hC);
    chk("t1_ins_c", instruction, 32'h8);

    // 2: consumer stalled, queue fills to DEPTH and stops requesting
    out_ready = 1'b0;
    do_reset();
    a0 = ack_cnt;
    repeat (5) step();
    chk("t2_cnt_full", count, 4);
    chk("t2_req_off", imem_req, 0);
    chk("t2_acks", ack_cnt - a0, 4);
    chk("t2_pc4", pc4, 32'h4);
    repeat (2) step();
    chk("t2_cnt_hold", count, 4);
    chk("t2_acks_hold", ack_cnt - a0, 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_cnt_pop", count, 3);
    chk("t2_req_on", imem_req, 1);
    chk("t2_addr", imem_addr, 32'h10);
    chk("t2_pc4_pop", pc4, 32'h8);

    // 3: three-cycle memory latency
    lat = 3;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t3_addr", imem_addr, 64'((i / 3) * 4));
      chk("t3_cnt", count, 64'(i / 3));
    end

    // 4: redirect with ack pending -> DISCARD, late 0xDEAD dropped
    redirect      = 1'b1;
    redirect_addr = 32'h103;
    dead          = 1'b1;
    step();
    redirect = 1'b0;
    chk("t4_req", imem_req, 1);
    chk("t4_old_addr", imem_addr, 32'h8);
    chk("t4_cnt", count, 0);
    chk("t4_valid", out_valid, 0);
    step();
    chk("t4_late_ack", imem_ack, 1);
    chk("t4_old_addr2", imem_addr, 32'h8);
    step();
    dead = 1'b0;
    chk("t4_idle_req", imem_req, 0);
    chk("t4_cnt_drop", count, 0);
    chk("t4_tgt", imem_addr, 32'h100);
    step();
    chk("t4_req_tgt", imem_req, 1);
    chk("t4_addr_tgt", imem_addr, 32'h100);
    lat = 0;
    step();
    chk("t4_pc4", pc4, 32'h104);
    chk("t4_ins", instruction, 32'h100);
    chk("t4_cnt1", count, 1);

    // 5: redirect coinciding with ack and pop at count=2
    step();
    chk("t5_cnt2", count, 2);
    chk("t5_ack", imem_ack, 1);
    chk("t5_head", pc4, 32'h104);
    redirect      = 1'b1;
    redirect_addr = 32'h200;
    out_ready     = 1'b1;
    step();
    redirect = 1'b0;
    chk("t5_cnt0", count, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_req", imem_req, 0);
    chk("t5_addr", imem_addr, 32'h200);
    step();
    chk("t5_req_tgt", imem_req, 1);
    chk("t5_addr_tgt", imem_addr, 32'h200);
    step();
    chk("t5_pc4", pc4, 32'h204);
    chk("t5_ins", instruction, 32'h200);
    chk("t5_cnt1", count, 1);

    // 6: asynchronous reset with count=3 mid-fetch
    out_ready = 1'b0;
    repeat (2) step();
    chk("t6_cnt3", count, 3);
    chk("t6_req", imem_req, 1);
    chk("t6_addr", imem_addr, 32'h20C);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_cnt", count, 0);
    chk("t6_rst_req", imem_req, 0);
    chk("t6_rst_addr", imem_addr, 0);
    reset = 1'b1;
    step();
    chk("t6_req_after", imem_req, 1);
    chk("t6_addr_after", imem_addr, 0);
    step();
    chk("t6_pc4_after", pc4, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
